// File: rtl/key_debounce_pkg.sv
// Shared definitions for the board key debouncer: channel state encoding and
// the 20 ms qualification constant for the 50 MHz board clock.
package de10_pkg;

    localparam int unsigned DEBOUNCE_20MS_50MHZ = 1000000;

    typedef enum logic [1:0] {
        IDLE_UP,
        WAIT_DOWN,
        HELD,
        WAIT_UP
    } ch_state_e;

    // Debounced level is a pure function of the qualified state.
    function automatic logic level_of(input ch_state_e s);
        return (s == HELD) || (s == WAIT_UP);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pins in, debounced level and press/release pulses out, one bit per key.
interface key_debounce_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    modport master (output key_n, input key_level, key_press, key_release);
    modport slave  (input key_n, output key_level, key_press, key_release);
endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: two-flop synchronizer, stability counter and a
// four-state qualifier with registered level and edge pulses.
module key_debounce_ch
    import de10_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             raw_s;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // NOTE: synchronizer resets to the released pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], key_n_i};
    end

    assign raw_s = ~sync_q[1];

    // NOTE: state is updated with non-blocking assignments only; the comb blocks compute _d.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_UP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE_UP: if (raw_s) begin
                state_d = WAIT_DOWN;
                cnt_d   = '0;
            end
            WAIT_DOWN: begin
                if (!raw_s) begin
                    state_d = IDLE_UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) state_d = HELD;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            HELD: if (!raw_s) begin
                state_d = WAIT_UP;
                cnt_d   = '0;
            end
            WAIT_UP: begin
                if (raw_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) state_d = IDLE_UP;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE_UP;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses come from the level edge, so a bounce back into HELD or IDLE_UP never pulses.
    always_comb begin
        level_d   = level_of(state_q);
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for N_KEYS active-low push buttons; each key gets a fully
// independent channel.
module key_debounce
    import de10_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input logic           clk,
    input logic           rst,
    key_debounce_if.slave kif
);
    logic [N_KEYS-1:0] level_w;
    logic [N_KEYS-1:0] press_w;
    logic [N_KEYS-1:0] release_w;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key_n_i   (kif.key_n[g]),
            .level_o   (level_w[g]),
            .press_o   (press_w[g]),
            .release_o (release_w[g])
        );
    end

    assign kif.key_level   = level_w;
    assign kif.key_press   = press_w;
    assign kif.key_release = release_w;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=8: a key change first sampled at
// edge t shows up as level/pulse at edge t+11.
module tb_key_debounce;
    localparam int DC  = 8;
    localparam int LAT = 12;  // from the drive point (just after edge e) to edge e+1+11

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_debounce_if #(.N_KEYS(2)) kif ();

    key_debounce #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    typedef struct {
        int         due;
        logic [1:0] press;
        logic [1:0] rel;
    } ev_t;

    typedef struct {
        logic [1:0] key_n;
        int         hold;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] level;
    } vec_t;

    ev_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    logic rst_seen = 1'b1;
    logic mon_en = 1'b0;
    logic [1:0] model_level = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [1:0] press, input logic [1:0] rel);
        sb_q.push_back('{due: edge_cnt + LAT, press: press, rel: rel});
    endtask

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen <= rst;
    end

    // Scoreboard monitor: pulses must appear exactly at queued edges, and the
    // level follows the pulses (or clears when reset was sampled).
    always @(negedge clk) begin
        logic [1:0] ep, er;
        if (mon_en) begin
            ep = 2'b00;
            er = 2'b00;
            if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
                ep = sb_q[0].press;
                er = sb_q[0].rel;
                sb_q.delete(0);
            end
            if (rst_seen) begin
                model_level = 2'b00;
                ep = 2'b00;
                er = 2'b00;
            end else begin
                model_level = (model_level | ep) & ~er;
            end
            check("mon_level", kif.key_level, model_level);
            check("mon_press", kif.key_press, ep);
            check("mon_release", kif.key_release, er);
            check("mon_exclusive", kif.key_press & kif.key_release, 2'b00);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        tbl[0]  = '{2'b10, 15, 2'b01, 2'b00, 2'b01};  // clean press key0
        tbl[1]  = '{2'b11, 15, 2'b00, 2'b01, 2'b00};
        tbl[2]  = '{2'b00, 15, 2'b11, 2'b00, 2'b11};  // both keys together
        tbl[3]  = '{2'b11, 15, 2'b00, 2'b11, 2'b00};
        tbl[4]  = '{2'b01, 15, 2'b10, 2'b00, 2'b10};  // key1 alone
        tbl[5]  = '{2'b11, 15, 2'b00, 2'b10, 2'b00};
        tbl[6]  = '{2'b10,  5, 2'b00, 2'b00, 2'b00};  // bounce: low 5
        tbl[7]  = '{2'b11,  1, 2'b00, 2'b00, 2'b00};  // high 1
        tbl[8]  = '{2'b10, 15, 2'b01, 2'b00, 2'b01};  // then held low
        tbl[9]  = '{2'b11,  3, 2'b00, 2'b00, 2'b01};  // release glitch
        tbl[10] = '{2'b10, 15, 2'b00, 2'b00, 2'b01};
        tbl[11] = '{2'b11, 15, 2'b00, 2'b01, 2'b00};
        tbl[12] = '{2'b10,  8, 2'b00, 2'b00, 2'b00};  // one sample short
        tbl[13] = '{2'b11, 15, 2'b00, 2'b00, 2'b00};
        tbl[14] = '{2'b10,  9, 2'b01, 2'b00, 2'b00};  // minimum qualifying press
        tbl[15] = '{2'b11, 15, 2'b00, 2'b01, 2'b00};

        kif.key_n = 2'b11;
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();
        check("rst_level", kif.key_level, 2'b00);
        check("rst_press", kif.key_press, 2'b00);
        check("rst_release", kif.key_release, 2'b00);
        rst = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < 16; i++) begin
            kif.key_n = tbl[i].key_n;
            if ((tbl[i].press | tbl[i].rel) != 2'b00) expect_ev(tbl[i].press, tbl[i].rel);
            repeat (tbl[i].hold) tick();
            check($sformatf("vec%0d_level", i), kif.key_level, tbl[i].level);
        end

        // Reset during WAIT_DOWN with the key held: requalified from scratch.
        kif.key_n = 2'b10;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("wd_rst_level", kif.key_level, 2'b00);
        check("wd_rst_press", kif.key_press, 2'b00);
        check("wd_rst_release", kif.key_release, 2'b00);
        rst = 1'b0;
        expect_ev(2'b01, 2'b00);
        repeat (15) tick();
        check("wd_after_level", kif.key_level, 2'b01);
        kif.key_n = 2'b11;
        expect_ev(2'b00, 2'b01);
        repeat (15) tick();
        check("wd_release_level", kif.key_level, 2'b00);

        // Reset while both keys are HELD: level drops with no release pulse.
        kif.key_n = 2'b00;
        expect_ev(2'b11, 2'b00);
        repeat (15) tick();
        check("held_level", kif.key_level, 2'b11);
        rst = 1'b1;
        tick();
        check("held_rst_level", kif.key_level, 2'b00);
        check("held_rst_release", kif.key_release, 2'b00);
        rst = 1'b0;
        expect_ev(2'b11, 2'b00);
        repeat (15) tick();
        check("held_requal_level", kif.key_level, 2'b11);
        kif.key_n = 2'b11;
        expect_ev(2'b00, 2'b11);
        repeat (15) tick();
        check("final_level", kif.key_level, 2'b00);
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter N_KEYS, default 2, number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required before a level change (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-003 SHALL have port clk, input, 1, sole clock (50 MHz board clock); one clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port key_n, input, N_KEYS, raw asynchronous push-button pins, active-low (0 = pressed).
REQ-006 SHALL have port key_level, output, N_KEYS, debounced state, active-high (1 = pressed).
REQ-007 SHALL have port key_press, output, N_KEYS, one-cycle pulse on debounced press.
REQ-008 SHALL have port key_release, output, N_KEYS, one-cycle pulse on debounced release.

Function
REQ-009 SHALL pass each key_n bit through a two-flop synchronizer; the second flop output is raw_s (pressed = ~key_n synchronized).
REQ-010 SHALL run one independent channel per key; channels SHALL NOT share counters or state.
REQ-011 Each channel SHALL implement states IDLE_UP, WAIT_DOWN, HELD, WAIT_UP.
REQ-012 IDLE_UP: raw_s=1 -> WAIT_DOWN with counter cleared to 0; else stay.
REQ-013 WAIT_DOWN: raw_s=0 -> IDLE_UP, counter cleared, no pulse; raw_s=1 and counter<DEBOUNCE_CYCLES-1 -> counter+1; raw_s=1 and counter=DEBOUNCE_CYCLES-1 -> HELD.
REQ-014 HELD: raw_s=0 -> WAIT_UP with counter cleared; else stay.
REQ-015 WAIT_UP mirrors WAIT_DOWN: raw_s=1 -> HELD, no pulse; raw_s=0 for DEBOUNCE_CYCLES consecutive cycles in WAIT_UP -> IDLE_UP.
REQ-016 key_level SHALL be registered: 1 in HELD and WAIT_UP, 0 in IDLE_UP and WAIT_DOWN.
REQ-017 key_press SHALL be 1 exactly in the first cycle key_level reads 1 after a WAIT_DOWN->HELD transition; key_release likewise for WAIT_UP->IDLE_UP.
REQ-018 key_press and key_release of one channel SHALL never be 1 in the same cycle.
REQ-019 Latency: key_n falling at edge t and held low -> key_level and key_press rise at edge t+2+DEBOUNCE_CYCLES+1 (2 sync, 1 entry, DEBOUNCE_CYCLES counting); release symmetric.
REQ-020 Any bounce (raw_s returning to the stable value) during a WAIT state SHALL restart qualification from zero on the next departure.
REQ-021 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap.
REQ-022 Simultaneous presses on multiple keys SHALL produce simultaneous pulses on each channel with identical latency.

Reset
REQ-023 rst=1 at an edge SHALL set synchronizer flops to 1 (released), state IDLE_UP, counter 0, key_level 0, key_press 0, key_release 0.
REQ-024 rst asserted during WAIT_DOWN or HELD SHALL abort with no pulse; a key held through reset deassertion SHALL be qualified from scratch (press pulse after full latency).
REQ-025 rst SHALL take priority over all other inputs.

Structure
REQ-026 Shared package de10_pkg SHALL hold the channel state enum and constant DEBOUNCE_20MS_50MHZ = 1000000.
REQ-027 Per-key logic (synchronizer, counter, FSM) SHALL be sub-module key_debounce_ch, instantiated N_KEYS times by generate.
REQ-028 No latches, no combinational path from key_n to any output.

Verification (DEBOUNCE_CYCLES=8, N_KEYS=2)
REQ-029 Clean press: key_n[0] 1->0 at edge 10, held -> key_level[0]=1 and key_press[0] pulse at edge 21 only; key 1 unaffected.
REQ-030 Bounce: key_n[0] low 5 cycles, high 1, then low held -> press pulse 11 cycles after final fall; no earlier pulse.
REQ-031 Release: from HELD, key_n[0] 0->1 held -> key_release[0] pulse and key_level[0]=0 11 cycles later; glitch of 3 cycles low then high yields no pulse.
REQ-032 Both keys pressed same cycle -> key_press=2'b11 in one cycle, key_level=2'b11.
REQ-033 rst pulse 1 cycle during WAIT_DOWN with key held -> no pulse during/after reset until 11 cycles after rst falls; all outputs 0 in reset cycle.
REQ-034 Pulse rule checker: every key_press/key_release is exactly 1 cycle, never coincident per channel, always matched by a key_level edge.
